path_streamer: RTL and testbench

//  Transmit side of the path/resend interface used by the Monte-Carlo pricing engine.
//  - Generates NUM_PATHS random-walk price paths, PATH_LEN words each, from an internal LFSR.
//  - Pulses start, streams the path words, and holds the strike K steady for the whole run.
//  - Replays the current path from its first word when the pricing core raises resend.
//  - Waits for the pricing result's valid, then reports done.

---
 rtl/path_streamer.sv | 184 ++++++++++++++++++
 tb/tb_path_streamer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/path_streamer.sv
// Transmit side of the Monte-Carlo path/resend link: streams NUM_PATHS LFSR-driven
// saturating random-walk paths, replays the current path on resend, then waits for the price.
module path_streamer #(
    parameter int          DW        = 12,
    parameter int          PATH_LEN  = 16,
    parameter int          NUM_PATHS = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [DW-1:0] s0,
    input  logic [DW-1:0] step,
    input  logic [DW-1:0] k_in,
    output logic          start,
    output logic [DW-1:0] path,
    output logic          path_vld,
    output logic [DW-1:0] K,
    input  logic          resend,
    input  logic          price_vld,
    output logic          busy,
    output logic          done
);

    localparam int WW = (PATH_LEN > 1) ? $clog2(PATH_LEN) : 1;
    localparam int PW = $clog2(NUM_PATHS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    localparam logic [WW-1:0] W_LAST = WW'(PATH_LEN - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_PATHS - 1);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] s0_q, s0_d;
    logic [DW-1:0] step_q, step_d;
    logic [DW-1:0] k_q, k_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   snap_q, snap_d;
    logic [DW-1:0] path_q, path_d;
    logic [WW-1:0] w_idx_q, w_idx_d;
    logic [PW-1:0] path_cnt_q, path_cnt_d;
    logic          start_q, start_d;
    logic          vld_q, vld_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // One random-walk step, computed one bit wider so overflow/underflow saturate instead of wrapping.
    function automatic logic [DW-1:0] walk_step(input logic [DW-1:0] prev,
                                                input logic [DW-1:0] stp,
                                                input logic          up);
        logic [DW:0] acc;
        if (up) begin
            acc = {1'b0, prev} + {1'b0, stp};
            return acc[DW] ? {DW{1'b1}} : acc[DW-1:0];
        end else begin
            acc = {1'b0, prev} - {1'b0, stp};
            return acc[DW] ? {DW{1'b0}} : acc[DW-1:0];
        end
    endfunction

    // Next-state logic for the run FSM, walk generator and output registers.
    always_comb begin
        state_d    = state_q;
        s0_d       = s0_q;
        step_d     = step_q;
        k_d        = k_q;
        lfsr_d     = lfsr_q;
        snap_d     = snap_q;
        path_d     = path_q;
        w_idx_d    = w_idx_q;
        path_cnt_d = path_cnt_q;
        start_d    = 1'b0;
        vld_d      = vld_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    s0_d    = s0;
                    step_d  = step;
                    k_d     = k_in;
                    lfsr_d  = LFSR_SEED;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                path_d     = s0_q;
                w_idx_d    = {WW{1'b0}};
                path_cnt_d = {PW{1'b0}};
                snap_d     = lfsr_q;
                vld_d      = 1'b1;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                // Replay takes priority over everything, including the final word of the run.
                if (resend) begin
                    path_d  = s0_q;
                    w_idx_d = {WW{1'b0}};
                    lfsr_d  = snap_q;
                end else if (w_idx_q == W_LAST) begin
                    if (path_cnt_q == P_LAST) begin
                        vld_d   = 1'b0;
                        state_d = S_WAIT;
                    end else begin
                        path_d     = s0_q;
                        w_idx_d    = {WW{1'b0}};
                        path_cnt_d = path_cnt_q + PW'(1);
                        snap_d     = lfsr_q;
                    end
                end else begin
                    path_d  = walk_step(path_q, step_q, lfsr_q[0]);
                    lfsr_d  = lfsr_next(lfsr_q);
                    w_idx_d = w_idx_q + WW'(1);
                end
            end
            S_WAIT: begin
                if (price_vld) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            s0_q       <= {DW{1'b0}};
            step_q     <= {DW{1'b0}};
            k_q        <= {DW{1'b0}};
            lfsr_q     <= LFSR_SEED;
            snap_q     <= LFSR_SEED;
            path_q     <= {DW{1'b0}};
            w_idx_q    <= {WW{1'b0}};
            path_cnt_q <= {PW{1'b0}};
            start_q    <= 1'b0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s0_q       <= s0_d;
            step_q     <= step_d;
            k_q        <= k_d;
            lfsr_q     <= lfsr_d;
            snap_q     <= snap_d;
            path_q     <= path_d;
            w_idx_q    <= w_idx_d;
            path_cnt_q <= path_cnt_d;
            start_q    <= start_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign start    = start_q;
    assign path     = path_q;
    assign path_vld = vld_q;
    assign K        = k_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_path_streamer.sv
// Scoreboard bench for path_streamer: an independent walk model queues the expected
// word stream per run; observed words are popped and compared as they appear.
module tb_path_streamer;

    localparam int          DW   = 12;
    localparam int          PL   = 16;
    localparam int          NP   = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst, go, resend, price_vld;
    logic [DW-1:0] s0, step, k_in;
    logic          start, path_vld, busy, done;
    logic [DW-1:0] path, k_out;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int s0_m, step_m;

    path_streamer #(.DW(DW), .PATH_LEN(PL), .NUM_PATHS(NP), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .go(go), .s0(s0), .step(step), .k_in(k_in),
        .start(start), .path(path), .path_vld(path_vld), .K(k_out),
        .resend(resend), .price_vld(price_vld), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
        end
    endtask

    // Queue the first nwords words of one path starting from LFSR state l_in; returns state after a full path.
    function automatic logic [15:0] push_path(input logic [15:0] l_in, input int nwords);
        logic [15:0] l;
        int v;
        l = l_in;
        v = s0_m;
        for (int w = 0; w < PL; w++) begin
            if (w > 0) begin
                v = l[0] ? v + step_m : v - step_m;
                if (v > 4095) v = 4095;
                if (v < 0) v = 0;
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
            if (w < nwords) exp_q.push_back(v);
        end
        return l;
    endfunction

    task automatic run(input int s0v, input int stepv, input int kv, input int rs_pos,
                       input int rs_len, input int go_pos, input int abort_pos);
        logic [15:0] l;
        int nw, cyc, e, last, total;
        exp_q.delete();
        s0_m = s0v;
        step_m = stepv;
        l = SEED;
        for (int p = 0; p < NP; p++) begin
            if (rs_pos >= 0 && p == rs_pos / PL) begin
                void'(push_path(l, rs_pos % PL + 1));
                for (int r = 1; r < rs_len; r++) exp_q.push_back(s0v);
            end
            l = push_path(l, PL);
        end
        total = exp_q.size();
        @(negedge clk);
        s0 = DW'(s0v); step = DW'(stepv); k_in = DW'(kv); go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_val("start_pulse", int'(start), 1);
        check_val("busy_start", int'(busy), 1);
        check_val("vld_start", int'(path_vld), 0);
        check_val("k_latch", int'(k_out), kv);
        @(negedge clk);
        check_val("start_clear", int'(start), 0);
        nw = 0; cyc = 0; last = 0;
        while (cyc < 2000 && path_vld) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check_val("word", int'(path), e);
            check_val("k_hold", int'(k_out), kv);
            check_val("done_in_stream", int'(done), 0);
            last = e;
            resend = (rs_pos >= 0 && nw >= rs_pos && nw < rs_pos + rs_len);
            go = (nw == go_pos);
            if (nw == go_pos) begin
                s0 = DW'(1); k_in = DW'(3000);
            end
            if (nw == abort_pos) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; resend = 1'b0; go = 1'b0;
                check_val("abort_busy", int'(busy), 0);
                check_val("abort_vld", int'(path_vld), 0);
                check_val("abort_path", int'(path), 0);
                check_val("abort_k", int'(k_out), 0);
                check_val("abort_start", int'(start), 0);
                check_val("abort_done", int'(done), 0);
                exp_q.delete();
                return;
            end
            nw++;
            @(negedge clk);
            go = 1'b0;
            cyc++;
        end
        resend = 1'b0;
        check_val("stream_timeout", int'(cyc < 2000), 1);
        check_val("n_words", nw, total);
        check_val("queue_empty", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            check_val("wait_busy", int'(busy), 1);
            check_val("wait_vld", int'(path_vld), 0);
            check_val("wait_path_hold", int'(path), last);
            check_val("wait_no_done", int'(done), 0);
            @(negedge clk);
        end
        price_vld = 1'b1;
        @(negedge clk);
        price_vld = 1'b0;
        check_val("done_pulse", int'(done), 1);
        check_val("busy_at_done", int'(busy), 0);
        @(negedge clk);
        check_val("done_clear", int'(done), 0);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; resend = 1'b0; price_vld = 1'b0;
        s0 = '0; step = '0; k_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("rst_start", int'(start), 0);
        check_val("rst_path", int'(path), 0);
        check_val("rst_vld", int'(path_vld), 0);
        check_val("rst_k", int'(k_out), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);

        // go coincident with rst: reset wins
        rst = 1'b1; go = 1'b1; k_in = DW'(77);
        @(negedge clk);
        rst = 1'b0; go = 1'b0;
        check_val("go_rst_busy", int'(busy), 0);
        check_val("go_rst_start", int'(start), 0);
        @(negedge clk);
        check_val("go_rst_start2", int'(start), 0);

        run(100, 0, 500, -1, 1, -1, -1);
        run(4090, 100, 10, -1, 1, -1, -1);
        run(50, 300, 20, -1, 1, -1, -1);
        for (int i = 0; i < 3; i++)
            run(int'($urandom_range(0, 4095)), int'($urandom_range(0, 600)), 30, -1, 1, -1, -1);
        run(1234, 50, 900, 2 * PL + 5, 1, -1, -1);
        run(1234, 50, 900, 7 * PL + 15, 1, -1, -1);
        run(3000, 200, 900, 3 * PL + 2, 3, -1, -1);
        run(800, 25, 2000, -1, 1, 40, -1);
        run(2000, 37, 700, -1, 1, -1, 60);
        run(2000, 37, 700, -1, 1, -1, -1);

        // price_vld while idle must not produce done
        @(negedge clk);
        price_vld = 1'b1;
        @(negedge clk);
        price_vld = 1'b0;
        check_val("idle_pv_done", int'(done), 0);
        check_val("idle_pv_busy", int'(busy), 0);
        @(negedge clk);
        check_val("idle_pv_done2", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
